// File: rtl/bcd_timer_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_timer_ctrl
//
// Two-digit BCD countdown timer with a four-state controller
// (IDLE, RUN, PAUSE, DONE).
//
// A preset is captured from preset_tens/preset_ones on load, with any digit
// above 9 clamped to 9. In RUN, each tick decrements the count in BCD.
// When a tick moves the count from 01 to 00, expire pulses for one cycle.
// After that the block either enters DONE or, when AUTO_RELOAD=1 and the
// preset is non-zero, reloads the preset and keeps running.
//
// Command priority within a cycle: rst > clear > load > pause > start > tick.
//
// Parameters
//   AUTO_RELOAD  1: reload the preset on expiry and stay in RUN
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   tick         one-cycle count-enable strobe from an external prescaler
//   start        begin or resume counting (IDLE/PAUSE, count != 00)
//   pause        freeze the count (RUN only)
//   clear        abort and reload the count from the preset register
//   load         capture the preset inputs (ignored in RUN)
//   preset_ones  preset ones digit, BCD
//   preset_tens  preset tens digit, BCD
//   bcd1         current ones digit
//   bcd2         current tens digit
//   running      registered decode of RUN
//   paused       registered decode of PAUSE
//   done         registered decode of DONE
//   expire       one-cycle pulse when a tick brings the count to 00
// -----------------------------------------------------------------------------
module bcd_timer_ctrl #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] preset_ones,
    input  logic [3:0] preset_tens,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       expire
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] preset_ones_q;
    logic [3:0] preset_tens_q;
    logic       count_zero;
    logic       count_one;
    logic       preset_zero;

    // Out-of-range BCD digits are clamped so the count can never exceed 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Status outputs are registered alongside the state, so they always
    // match the state register with no decode glitches.
    function automatic logic [2:0] flags_of(input state_t s);
        return {s == S_RUN, s == S_PAUSE, s == S_DONE};
    endfunction

    assign count_zero  = (bcd2 == 4'd0) && (bcd1 == 4'd0);
    assign count_one   = (bcd2 == 4'd0) && (bcd1 == 4'd1);
    assign preset_zero = (preset_tens_q == 4'd0) && (preset_ones_q == 4'd0);

    // NOTE: all state here is updated with non-blocking assignments, so every
    // branch reads the pre-edge values of the state, the count and the preset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the preset register is state like any other and is
            // cleared on reset, so a clear right after reset reloads 00.
            state                   <= S_IDLE;
            {running, paused, done} <= 3'b000;
            expire                  <= 1'b0;
            bcd1                    <= 4'd0;
            bcd2                    <= 4'd0;
            preset_ones_q           <= 4'd0;
            preset_tens_q           <= 4'd0;
        end else begin
            expire <= 1'b0;

            if (clear) begin
                bcd1                    <= preset_ones_q;
                bcd2                    <= preset_tens_q;
                state                   <= S_IDLE;
                {running, paused, done} <= flags_of(S_IDLE);
            end else if (load && state != S_RUN) begin
                preset_ones_q           <= clamp_digit(preset_ones);
                preset_tens_q           <= clamp_digit(preset_tens);
                bcd1                    <= clamp_digit(preset_ones);
                bcd2                    <= clamp_digit(preset_tens);
                state                   <= S_IDLE;
                {running, paused, done} <= flags_of(S_IDLE);
            end else if (pause && state == S_RUN) begin
                state                   <= S_PAUSE;
                {running, paused, done} <= flags_of(S_PAUSE);
            end else if (start && (state == S_IDLE || state == S_PAUSE)
                         && !count_zero) begin
                // A tick in this same cycle is consumed by the start.
                state                   <= S_RUN;
                {running, paused, done} <= flags_of(S_RUN);
            end else if (tick && state == S_RUN && !load) begin
                // A load in RUN is ignored, but it still swallows the tick.
                if (count_one) begin
                    expire <= 1'b1;
                    if (AUTO_RELOAD && !preset_zero) begin
                        bcd1 <= preset_ones_q;
                        bcd2 <= preset_tens_q;
                    end else begin
                        bcd1                    <= 4'd0;
                        bcd2                    <= 4'd0;
                        state                   <= S_DONE;
                        {running, paused, done} <= flags_of(S_DONE);
                    end
                end else if (bcd1 != 4'd0) begin
                    bcd1 <= bcd1 - 4'd1;
                end else if (bcd2 != 4'd0) begin
                    // Ones borrow: x0 -> (x-1)9.
                    bcd1 <= 4'd9;
                    bcd2 <= bcd2 - 4'd1;
                end else begin
                    // A count of 00 in RUN cannot normally occur. Park in
                    // DONE without an expire pulse if it ever does.
                    state                   <= S_DONE;
                    {running, paused, done} <= flags_of(S_DONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_timer_ctrl
//
// Directed testbench for bcd_timer_ctrl. It drives two instances from the
// same inputs: one with AUTO_RELOAD=0 and one with AUTO_RELOAD=1. Each
// section checks only the instance it is written for. Expected counts and
// status values are computed by hand.
//
// Status is compared as a 4-bit vector {running, paused, done, expire}.
// -----------------------------------------------------------------------------
module tb_bcd_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] preset_ones = 4'd0;
    logic [3:0] preset_tens = 4'd0;

    logic [3:0] bcd1, bcd2;
    logic       running, paused, done, expire;
    logic [3:0] ar_bcd1, ar_bcd2;
    logic       ar_running, ar_paused, ar_done, ar_expire;

    int passed = 0;
    int total  = 0;

    localparam logic [3:0] ST_IDLE  = 4'b0000;
    localparam logic [3:0] ST_RUN   = 4'b1000;
    localparam logic [3:0] ST_PAUSE = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b0010;
    localparam logic [3:0] ST_EXP   = 4'b0001;

    bcd_timer_ctrl #(.AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .load(load), .preset_ones(preset_ones),
        .preset_tens(preset_tens), .bcd1(bcd1), .bcd2(bcd2),
        .running(running), .paused(paused), .done(done), .expire(expire)
    );

    bcd_timer_ctrl #(.AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .load(load), .preset_ones(preset_ones),
        .preset_tens(preset_tens), .bcd1(ar_bcd1), .bcd2(ar_bcd2),
        .running(ar_running), .paused(ar_paused), .done(ar_done),
        .expire(ar_expire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // Wait for one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd_of(input int n);
        logic [3:0] t, o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    function automatic logic [7:0] st();
        return {4'b0, running, paused, done, expire};
    endfunction

    function automatic logic [7:0] ar_st();
        return {4'b0, ar_running, ar_paused, ar_done, ar_expire};
    endfunction

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_count", {bcd2, bcd1}, 8'h00);
        check("rst_status", st(), {4'b0, ST_IDLE});

        // ---------------- preset 12, count to 00 ----------------
        preset_tens = 4'd1; preset_ones = 4'd2; load = 1'b1; step(); load = 1'b0;
        check("load12_count", {bcd2, bcd1}, 8'h12);
        check("load12_status", st(), {4'b0, ST_IDLE});
        start = 1'b1; step(); start = 1'b0;
        check("start12_count", {bcd2, bcd1}, 8'h12);
        check("start12_status", st(), {4'b0, ST_RUN});
        for (int i = 1; i <= 12; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            check($sformatf("t12_count_%0d", i), {bcd2, bcd1}, bcd_of(12 - i));
            check($sformatf("t12_status_%0d", i), st(),
                  (i == 12) ? {4'b0, ST_DONE | ST_EXP} : {4'b0, ST_RUN});
        end
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            check($sformatf("done_hold_count_%0d", i), {bcd2, bcd1}, 8'h00);
            check($sformatf("done_hold_status_%0d", i), st(), {4'b0, ST_DONE});
        end

        // ---------------- clamp on load (from DONE) ----------------
        preset_tens = 4'hF; preset_ones = 4'hC; load = 1'b1; step(); load = 1'b0;
        check("clamp_count", {bcd2, bcd1}, 8'h99);
        check("clamp_status", st(), {4'b0, ST_IDLE});

        // ---------------- preset 20: borrow, pause, resume ----------------
        preset_tens = 4'd2; preset_ones = 4'd0; load = 1'b1; step(); load = 1'b0;
        check("load20_count", {bcd2, bcd1}, 8'h20);
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check("borrow_count", {bcd2, bcd1}, 8'h19);
        pause = 1'b1; step(); pause = 1'b0;
        check("pause_status", st(), {4'b0, ST_PAUSE});
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        check("paused_ticks_count", {bcd2, bcd1}, 8'h19);
        check("paused_ticks_status", st(), {4'b0, ST_PAUSE});
        start = 1'b1; step(); start = 1'b0;
        check("resume_count", {bcd2, bcd1}, 8'h19);
        check("resume_status", st(), {4'b0, ST_RUN});
        tick = 1'b1; step(); tick = 1'b0;
        check("resume_tick_count", {bcd2, bcd1}, 8'h18);
        // pause and tick together: pause wins, no decrement
        pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
        check("pause_tick_count", {bcd2, bcd1}, 8'h18);
        check("pause_tick_status", st(), {4'b0, ST_PAUSE});

        // ---------------- start+tick at 05, then clear mid-RUN ----------------
        preset_tens = 4'd0; preset_ones = 4'd5; load = 1'b1; step(); load = 1'b0;
        check("load05_status", st(), {4'b0, ST_IDLE});
        start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
        check("start_tick_count", {bcd2, bcd1}, 8'h05);
        check("start_tick_status", st(), {4'b0, ST_RUN});
        tick = 1'b1; step(); step(); tick = 1'b0;
        check("pre_clear_count", {bcd2, bcd1}, 8'h03);
        clear = 1'b1; tick = 1'b1; step(); clear = 1'b0; tick = 1'b0;
        check("clear_count", {bcd2, bcd1}, 8'h05);
        check("clear_status", st(), {4'b0, ST_IDLE});

        // ---------------- reset mid-RUN at 07 ----------------
        preset_tens = 4'd0; preset_ones = 4'd9; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); step(); tick = 1'b0;
        check("pre_rst_count", {bcd2, bcd1}, 8'h07);
        rst = 1'b1; tick = 1'b1; step(); rst = 1'b0; tick = 1'b0;
        check("mid_rst_count", {bcd2, bcd1}, 8'h00);
        check("mid_rst_status", st(), {4'b0, ST_IDLE});
        start = 1'b1; step(); start = 1'b0;
        check("start_at_00_status", st(), {4'b0, ST_IDLE});
        // the preset register was reset too, so clear reloads 00 rather than 09
        clear = 1'b1; step(); clear = 1'b0;
        check("rst_preset_count", {bcd2, bcd1}, 8'h00);

        // ---------------- AUTO_RELOAD=1, preset 03 ----------------
        rst = 1'b1; step(); rst = 1'b0;
        preset_tens = 4'd0; preset_ones = 4'd3; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check("ar_start_status", ar_st(), {4'b0, ST_RUN});
        begin
            logic [7:0] ar_exp_count [6];
            logic [3:0] ar_exp_st [6];
            ar_exp_count = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
            ar_exp_st    = '{ST_RUN, ST_RUN, ST_RUN | ST_EXP,
                             ST_RUN, ST_RUN, ST_RUN | ST_EXP};
            for (int i = 0; i < 6; i++) begin
                tick = 1'b1; step(); tick = 1'b0;
                check($sformatf("ar_count_%0d", i), {ar_bcd2, ar_bcd1}, ar_exp_count[i]);
                check($sformatf("ar_status_%0d", i), ar_st(), {4'b0, ar_exp_st[i]});
            end
        end
        // load in RUN is ignored and the coinciding tick does not decrement
        preset_tens = 4'd9; preset_ones = 4'd9; load = 1'b1; tick = 1'b1; step();
        load = 1'b0; tick = 1'b0;
        check("ar_load_in_run_count", {ar_bcd2, ar_bcd1}, 8'h03);
        check("ar_load_in_run_status", ar_st(), {4'b0, ST_RUN});
        tick = 1'b1; step(); tick = 1'b0;
        check("ar_after_load_count", {ar_bcd2, ar_bcd1}, 8'h02);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter: AUTO_RELOAD, 0, when 1 the block reloads the stored preset on reaching 00 and keeps running instead of entering DONE.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: tick  input  1  count-enable strobe, one cycle wide, from an external prescaler.
REQ-005 Port: start  input  1  level-sampled command: begin or resume counting.
REQ-006 Port: pause  input  1  level-sampled command: freeze count.
REQ-007 Port: clear  input  1  level-sampled command: abort and reload preset.
REQ-008 Port: load  input  1  level-sampled command: capture preset_tens/preset_ones into the preset register.
REQ-009 Port: preset_ones  input  4  preset ones digit, BCD.
REQ-010 Port: preset_tens  input  4  preset tens digit, BCD.
REQ-011 Port: bcd1  output  4  current ones digit.
REQ-012 Port: bcd2  output  4  current tens digit.
REQ-013 Port: running  output  1  high while in RUN.
REQ-014 Port: paused  output  1  high while in PAUSE.
REQ-015 Port: done  output  1  high while in DONE.
REQ-016 Port: expire  output  1  one-cycle pulse when the count transitions to 00 by a tick.

Function
REQ-017 The block SHALL implement a 4-state FSM: IDLE, RUN, PAUSE, DONE. Outputs running/paused/done SHALL be registered decodes of the state.
REQ-018 Command priority within one cycle SHALL be: rst > clear > load > pause > start > tick.
REQ-019 load in IDLE, PAUSE or DONE SHALL write the preset register and the count {bcd2,bcd1} from the preset inputs next cycle, then enter IDLE. load in RUN SHALL be ignored.
REQ-020 Any preset digit >9 SHALL be clamped to 9 on capture.
REQ-021 clear in any state SHALL copy the preset register into {bcd2,bcd1} and enter IDLE next cycle.
REQ-022 start in IDLE or PAUSE with count != 00 SHALL enter RUN next cycle. start with count == 00 SHALL be ignored.
REQ-023 pause in RUN SHALL enter PAUSE next cycle with the count held. pause in other states SHALL be ignored.
REQ-024 In RUN, each tick SHALL decrement the count by one in BCD: ones 1..9 -> ones-1; ones 0 -> ones 9 and tens-1.
REQ-025 The tick that moves the count from 01 to 00 SHALL assert expire for exactly that cycle's next clock. With AUTO_RELOAD=0 the FSM SHALL enter DONE with the count 00. With AUTO_RELOAD=1 the count SHALL reload from the preset register and the FSM SHALL remain in RUN.
REQ-026 AUTO_RELOAD=1 with a preset of 00 SHALL behave as AUTO_RELOAD=0 (enter DONE).
REQ-027 A tick coinciding with start in IDLE/PAUSE SHALL not decrement; counting SHALL begin on the first tick after RUN is entered.
REQ-028 A tick coinciding with pause, clear or load SHALL not decrement.
REQ-029 Ticks outside RUN SHALL have no effect. DONE SHALL persist until clear or load.
REQ-030 bcd1/bcd2 SHALL never hold a value >9.

Reset
REQ-031 rst SHALL set state IDLE, the preset register 00, bcd1=0, bcd2=0, and running=paused=done=expire=0 on the next clock edge. Asserting rst mid-RUN SHALL abort with no expire pulse.

Verification
REQ-032 Scenario: load preset 12, start, then 12 ticks -> counts 11,10,09,...,01,00; expire pulses once on the 12th; done=1; count stays 00 under further ticks.
REQ-033 Scenario: preset 20, start, 1 tick -> 19 (ones borrow). Pause, then 5 ticks -> stays 19 with paused=1. Start, then 1 tick -> 18.
REQ-034 Scenario: AUTO_RELOAD=1, preset 03, start, 6 ticks -> 02,01,00->reload 03 (expire), 02,01,03 (second expire); running stays 1 throughout.
REQ-035 Scenario: preset_ones=4'hC, preset_tens=4'hF, load -> bcd2=9, bcd1=9.
REQ-036 Scenario: start and tick in the same cycle from IDLE at 05 -> count still 05 in the next cycle, running=1. Clear mid-RUN at 03 -> IDLE with the preset reloaded.
REQ-037 Scenario: rst asserted mid-RUN at 07 -> next cycle all outputs 0, state IDLE; start at 00 is ignored (running stays 0).
